// File: rtl/ahb_axi_pkg.sv
// Shared encodings for the AHB-Lite to AXI4-Lite bridge family: bus codes,
// response helpers and the bridge control-state enumeration.
package ahb_axi_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WR    = 3'd1,
    ST_WRESP = 3'd2,
    ST_RD    = 3'd3,
    ST_RDATA = 3'd4,
    ST_DONE  = 3'd5,
    ST_ERR1  = 3'd6,
    ST_ERR2  = 3'd7
  } state_e;

  function automatic logic axi_resp_is_err(input logic [1:0] resp);
    return (resp == AXI_RESP_SLVERR) || (resp == AXI_RESP_DECERR);
  endfunction

endpackage

// File: rtl/ahb_axi_strb.sv
// Byte-lane strobe generation for a 32-bit data path from AHB size and low
// address bits; flags misaligned accesses and sizes wider than a word.
module ahb_axi_strb (
  input  logic [2:0] hsize_i,
  input  logic [1:0] addr_lo_i,
  output logic [3:0] wstrb_o,
  output logic       misaligned_o
);

  always_comb begin
    wstrb_o      = 4'b0000;
    misaligned_o = 1'b0;
    case (hsize_i)
      3'b000: wstrb_o = 4'b0001 << addr_lo_i;
      3'b001: begin
        wstrb_o      = 4'b0011 << {addr_lo_i[1], 1'b0};
        misaligned_o = addr_lo_i[0];
      end
      3'b010: begin
        wstrb_o      = 4'b1111;
        misaligned_o = |addr_lo_i;
      end
      // Anything wider than a word cannot be carried on this data path.
      default: misaligned_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/ahb_axi4lite_bridge.sv
// AHB-Lite slave to AXI4-Lite master bridge: one transfer outstanding, AHB is
// stalled until the AXI response returns, AXI errors become an AHB ERROR pair.
module ahb_axi4lite_bridge
  import ahb_axi_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              hclk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] ahb_haddr,
  input  logic [1:0]        ahb_htrans,
  input  logic              ahb_hwrite,
  input  logic [2:0]        ahb_hsize,
  input  logic [3:0]        ahb_hprot,
  input  logic [DATA_W-1:0] ahb_hwdata,
  input  logic              ahb_hsel,
  input  logic              ahb_hready,
  output logic [DATA_W-1:0] ahb_hrdata,
  output logic              ahb_hreadyout,
  output logic [1:0]        ahb_hresp,
  output logic [ADDR_W-1:0] axi_awaddr,
  output logic [2:0]        axi_awprot,
  output logic              axi_awvalid,
  input  logic              axi_awready,
  output logic [DATA_W-1:0] axi_wdata,
  output logic [3:0]        axi_wstrb,
  output logic              axi_wvalid,
  input  logic              axi_wready,
  input  logic [1:0]        axi_bresp,
  input  logic              axi_bvalid,
  output logic              axi_bready,
  output logic [ADDR_W-1:0] axi_araddr,
  output logic [2:0]        axi_arprot,
  output logic              axi_arvalid,
  input  logic              axi_arready,
  input  logic [DATA_W-1:0] axi_rdata,
  input  logic [1:0]        axi_rresp,
  input  logic              axi_rvalid,
  output logic              axi_rready
);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [2:0]          prot_q, prot_d;
  logic [3:0]          wstrb_q, wstrb_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   hrdata_q, hrdata_d;
  logic                hreadyout_q, hreadyout_d;
  logic [1:0]          hresp_q, hresp_d;
  logic                awvalid_q, awvalid_d;
  logic                wvalid_q, wvalid_d;
  logic                arvalid_q, arvalid_d;
  logic                bready_q, bready_d;
  logic                rready_q, rready_d;
  logic                aw_done_q, aw_done_d;
  logic                w_done_q, w_done_d;

  logic [3:0]          strb;
  logic                strb_err;
  logic                accept;
  logic                unused_hprot;

  assign unused_hprot = ^ahb_hprot[3:2];

  ahb_axi_strb u_strb (
    .hsize_i      (ahb_hsize),
    .addr_lo_i    (ahb_haddr[1:0]),
    .wstrb_o      (strb),
    .misaligned_o (strb_err)
  );

  assign accept = ahb_hsel && ahb_hready && hreadyout_q &&
                  ((ahb_htrans == HTRANS_NONSEQ) || (ahb_htrans == HTRANS_SEQ));

  // NOTE: every _d gets its _q value first so no path through the case can
  // leave a variable unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    prot_d    = prot_q;
    wstrb_d   = wstrb_q;
    wdata_d   = wdata_q;
    hrdata_d  = hrdata_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    arvalid_d = arvalid_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;

    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR2: begin
        state_d = ST_IDLE;
        if (accept) begin
          addr_d    = ahb_haddr;
          prot_d    = {~ahb_hprot[0], 1'b0, ahb_hprot[1]};
          wstrb_d   = strb;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          if (strb_err) begin
            state_d = ST_ERR1;
          end else if (ahb_hwrite) begin
            state_d   = ST_WR;
            awvalid_d = 1'b1;
          end else begin
            state_d   = ST_RD;
            arvalid_d = 1'b1;
          end
        end
      end
      ST_WR: begin
        // Write data is only on the AHB bus in the cycle after the address phase.
        if (!wvalid_q && !w_done_q) begin
          wvalid_d = 1'b1;
          wdata_d  = ahb_hwdata;
        end
        if (awvalid_q && axi_awready) begin
          awvalid_d = 1'b0;
          aw_done_d = 1'b1;
        end
        if (wvalid_q && axi_wready) begin
          wvalid_d = 1'b0;
          w_done_d = 1'b1;
        end
        if (aw_done_d && w_done_d) state_d = ST_WRESP;
      end
      ST_WRESP: begin
        if (axi_bvalid) state_d = axi_resp_is_err(axi_bresp) ? ST_ERR1 : ST_DONE;
      end
      ST_RD: begin
        if (axi_arready) begin
          arvalid_d = 1'b0;
          state_d   = ST_RDATA;
        end
      end
      ST_RDATA: begin
        if (axi_rvalid) begin
          hrdata_d = axi_rdata;
          state_d  = axi_resp_is_err(axi_rresp) ? ST_ERR1 : ST_DONE;
        end
      end
      ST_ERR1: state_d = ST_ERR2;
      default: state_d = ST_IDLE;
    endcase

    // Handshake outputs are decoded from the next state so they leave flops.
    hreadyout_d = (state_d == ST_IDLE) || (state_d == ST_DONE) || (state_d == ST_ERR2);
    hresp_d     = ((state_d == ST_ERR1) || (state_d == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
    bready_d    = (state_d == ST_WRESP);
    rready_d    = (state_d == ST_RDATA);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge hclk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      prot_q      <= '0;
      wstrb_q     <= '0;
      wdata_q     <= '0;
      hrdata_q    <= '0;
      hreadyout_q <= 1'b1;
      hresp_q     <= HRESP_OKAY;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      bready_q    <= 1'b0;
      rready_q    <= 1'b0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      prot_q      <= prot_d;
      wstrb_q     <= wstrb_d;
      wdata_q     <= wdata_d;
      hrdata_q    <= hrdata_d;
      hreadyout_q <= hreadyout_d;
      hresp_q     <= hresp_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      arvalid_q   <= arvalid_d;
      bready_q    <= bready_d;
      rready_q    <= rready_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
    end
  end

  assign ahb_hrdata    = hrdata_q;
  assign ahb_hreadyout = hreadyout_q;
  assign ahb_hresp     = hresp_q;
  assign axi_awaddr    = addr_q;
  assign axi_awprot    = prot_q;
  assign axi_awvalid   = awvalid_q;
  assign axi_wdata     = wdata_q;
  assign axi_wstrb     = wstrb_q;
  assign axi_wvalid    = wvalid_q;
  assign axi_bready    = bready_q;
  assign axi_araddr    = addr_q;
  assign axi_arprot    = prot_q;
  assign axi_arvalid   = arvalid_q;
  assign axi_rready    = rready_q;

endmodule
